// File: rtl/rst_seq_gen_pkg.sv
// Shared types and helpers for the staggered reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Edge index (counted from the restart point) at which channel k is released.
  function automatic int unsigned rel_edge(input int unsigned init_cycles,
                                           input int unsigned stagger,
                                           input int unsigned k);
    return init_cycles + k * stagger;
  endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Bundle of the sequencer's control and status signals for system-level hookup.
interface rst_seq_gen_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned REL_W = $clog2(NUM_CH + 1);

  logic              req_i;
  logic              hold_i;
  logic [NUM_CH-1:0] rst_o;
  logic [REL_W-1:0]  rel_cnt_o;
  logic              done_o;

  modport master (output req_i, hold_i, input rst_o, rel_cnt_o, done_o);
  modport slave  (input req_i, hold_i, output rst_o, rel_cnt_o, done_o);
endinterface

// File: rtl/rst_seq_gen.sv
// Staggered multi-channel reset sequencer: holds all channels for INIT_CYCLES,
// then releases them one at a time every STAGGER cycles.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int unsigned        NUM_CH      = 4,
  parameter int unsigned        INIT_CYCLES = 4,
  parameter int unsigned        STAGGER     = 2,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [NUM_CH-1:0]  ACT_LOW     = '0,
  localparam int unsigned       REL_W       = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic              hold_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic [REL_W-1:0]  rel_cnt_o,
  output logic              done_o
);

  localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_CYCLES);
  localparam logic [CNT_W-1:0] STAG_C   = CNT_W'(STAGGER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [REL_W-1:0] REL_ONE  = REL_W'(1);
  localparam logic [REL_W-1:0] REL_ALL  = REL_W'(NUM_CH);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(NUM_CH - 1);
  // A single channel or zero stagger releases everything on the INIT edge.
  localparam bit ALL_AT_ONCE = (STAGGER == 0) || (NUM_CH == 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [REL_W-1:0]  rel_q, rel_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] rst_q, rst_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    done_d  = done_q;
    if (req_i) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      rel_d   = '0;
      done_d  = 1'b0;
    end else if (!(hold_i && (state_q != ST_DONE))) begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == INIT_C) begin
            if (ALL_AT_ONCE) begin
              rel_d   = REL_ALL;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              rel_d   = REL_ONE;
              cnt_d   = CNT_ONE;
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAG_C) begin
            rel_d = rel_q + REL_ONE;
            cnt_d = CNT_ONE;
            if (rel_q == REL_LAST) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_DONE: begin
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rel_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Channel k stays asserted until k channels have been released before it.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign rst_d[gi] = (REL_W'(gi) >= rel_d) ^ ACT_LOW[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rel_q   <= '0;
      done_q  <= 1'b0;
      rst_q   <= ~ACT_LOW;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
      rst_q   <= rst_d;
    end
  end

  assign rst_o     = rst_q;
  assign rel_cnt_o = rel_q;
  assign done_o    = done_q;

endmodule
